// File: rtl/krnl_vadd_rtl_example_axi_slave_mem.sv
// krnl_vadd_rtl_example_axi_slave_mem: AXI4 INCR-burst memory responder backed by a word-addressed array
// Ports: aclk/areset (sync, active-high); AW/W/B write channel (response always OKAY);
// AR/R read channel; err_wlast sticky flag for a misplaced wlast.
module krnl_vadd_rtl_example_axi_slave_mem #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_WORDS = 1024
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW = $clog2(C_MEM_DEPTH_WORDS);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH_WORDS];
  w_state_t w_state_q, w_state_d;
  logic [IW-1:0] w_idx_q, w_idx_d;
  logic [7:0] w_len_q, w_len_d;
  logic [8:0] w_cnt_q, w_cnt_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, err_q, err_d;
  r_state_t r_state_q, r_state_d;
  logic [IW-1:0] r_idx_q, r_idx_d;
  logic [8:0] r_rem_q, r_rem_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IW-1:0] aw_idx, ar_idx;
  logic aw_fire, w_fire, ar_fire, r_fire, w_final;
  logic unused_addr;
  // Only the index bits of the byte address matter; offset and high bits are dropped.
  assign aw_idx = s_axi_awaddr[OFS +: IW];
  assign ar_idx = s_axi_araddr[OFS +: IW];
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};
  assign aw_fire = awready_q & s_axi_awvalid;
  assign w_fire = wready_q & s_axi_wvalid;
  assign ar_fire = arready_q & s_axi_arvalid;
  assign r_fire = rvalid_q & s_axi_rready;
  assign w_final = w_cnt_q == {1'b0, w_len_q};
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d = w_idx_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    err_d = err_q;
    case (w_state_q)
      W_IDLE: if (aw_fire) begin
        w_state_d = W_DATA;
        w_idx_d = aw_idx;
        w_len_d = s_axi_awlen;
        w_cnt_d = '0;
      end
      W_DATA: if (w_fire) begin
        w_idx_d = w_idx_q + 1'b1;
        w_cnt_d = w_cnt_q + 1'b1;
        err_d = err_q | (s_axi_wlast != w_final);
        w_state_d = w_final ? W_RESP : W_DATA;
      end
      default: if (bvalid_q & s_axi_bready) w_state_d = W_IDLE;
    endcase
    awready_d = w_state_d == W_IDLE;
    wready_d = w_state_d == W_DATA;
    bvalid_d = w_state_d == W_RESP;
  end
  // r_rem counts beats still to come after the one currently presented on R.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d = r_idx_q;
    r_rem_d = r_rem_q;
    rlast_d = rlast_q;
    rdata_d = rdata_q;
    case (r_state_q)
      R_IDLE: if (ar_fire) begin
        r_state_d = R_DATA;
        rdata_d = mem_q[ar_idx];
        r_idx_d = ar_idx + 1'b1;
        r_rem_d = {1'b0, s_axi_arlen};
        rlast_d = s_axi_arlen == 8'd0;
      end
      default: if (r_fire) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rlast_d = 1'b0;
        end else begin
          rdata_d = mem_q[r_idx_q];
          r_idx_d = r_idx_q + 1'b1;
          r_rem_d = r_rem_q - 1'b1;
          rlast_d = r_rem_q == 9'd1;
        end
      end
    endcase
    arready_d = r_state_d == R_IDLE;
    rvalid_d = r_state_d == R_DATA;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_idx_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      err_q <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q <= '0;
      r_rem_q <= '0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q <= w_idx_d;
      w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      err_q <= err_d;
      r_state_q <= r_state_d;
      r_idx_q <= r_idx_d;
      r_rem_q <= r_rem_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rdata_q <= rdata_d;
    end
  end
  // Read data is captured from the pre-edge array, so a same-cycle write is seen only by later reads.
  always_ff @(posedge aclk)
    if (!areset && w_fire)
      for (int k = 0; k < NB; k++)
        if (s_axi_wstrb[k]) mem_q[w_idx_q][8*k +: 8] <= s_axi_wdata[8*k +: 8];
  assign s_axi_awready = awready_q;
  assign s_axi_wready = wready_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rlast = rlast_q;
  assign err_wlast = err_q;
endmodule

// File: tb/tb_krnl_vadd_rtl_example_axi_slave_mem.sv
// tb_krnl_vadd_rtl_example_axi_slave_mem: directed self-checking bench for the AXI memory responder
module tb_krnl_vadd_rtl_example_axi_slave_mem;
  logic aclk = 0, areset = 1;
  logic s_axi_awvalid = 0, s_axi_awready;
  logic [63:0] s_axi_awaddr = '0;
  logic [7:0] s_axi_awlen = '0;
  logic s_axi_wvalid = 0, s_axi_wready;
  logic [511:0] s_axi_wdata = '0;
  logic [63:0] s_axi_wstrb = '0;
  logic s_axi_wlast = 0;
  logic s_axi_bvalid, s_axi_bready = 0;
  logic s_axi_arvalid = 0, s_axi_arready;
  logic [63:0] s_axi_araddr = '0;
  logic [7:0] s_axi_arlen = '0;
  logic s_axi_rvalid, s_axi_rready = 0;
  logic [511:0] s_axi_rdata;
  logic s_axi_rlast, err_wlast;
  int asserts = 0, fails = 0;
  krnl_vadd_rtl_example_axi_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .err_wlast(err_wlast)
  );
  always #5 aclk = ~aclk;
  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [511:0] val(input int i);
    logic [31:0] t;
    t = i ^ 32'h5A5A_0000;
    return {16{t}};
  endfunction
  task automatic do_aw(input logic [63:0] a, input logic [7:0] l);
    int n = 0;
    s_axi_awvalid = 1; s_axi_awaddr = a; s_axi_awlen = l;
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    asserts++;
    if (!s_axi_awready) begin fails++; $display("FAIL aw_timeout awready=%b exp 1", s_axi_awready); end
    @(negedge aclk);
    s_axi_awvalid = 0;
  endtask
  task automatic do_ar(input logic [63:0] a, input logic [7:0] l);
    int n = 0;
    s_axi_arvalid = 1; s_axi_araddr = a; s_axi_arlen = l;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    asserts++;
    if (!s_axi_arready) begin fails++; $display("FAIL ar_timeout arready=%b exp 1", s_axi_arready); end
    @(negedge aclk);
    s_axi_arvalid = 0;
  endtask
  task automatic do_w(input logic [511:0] d, input logic [63:0] s, input logic l);
    int n = 0;
    s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = l;
    while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
    asserts++;
    if (!s_axi_wready) begin fails++; $display("FAIL w_timeout wready=%b exp 1", s_axi_wready); end
    @(negedge aclk);
  endtask
  task automatic do_b();
    int n = 0;
    s_axi_bready = 1;
    while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
    asserts++;
    if (!s_axi_bvalid) begin fails++; $display("FAIL b_timeout bvalid=%b exp 1", s_axi_bvalid); end
    @(negedge aclk);
    s_axi_bready = 0;
  endtask
  task automatic write1(input logic [63:0] a, input logic [511:0] d, input logic [63:0] s);
    do_aw(a, 8'd0);
    do_w(d, s, 1'b1);
    s_axi_wvalid = 0;
    do_b();
  endtask
  task automatic read1(input logic [63:0] a, output logic [511:0] d, output logic l);
    do_ar(a, 8'd0);
    d = s_axi_rdata; l = s_axi_rlast;
    s_axi_rready = 1;
    @(negedge aclk);
    s_axi_rready = 0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge aclk);
    asserts++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, err_wlast} !== 7'b0 || s_axi_rdata !== '0) begin
      fails++; $display("FAIL reset_outputs got aw%b w%b b%b ar%b r%b l%b e%b rdata=%h exp all 0", s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, err_wlast, s_axi_rdata);
    end
    areset = 0;
    @(negedge aclk);
    asserts++;
    if (s_axi_awready !== 1 || s_axi_arready !== 1 || s_axi_wready !== 0 || s_axi_bvalid !== 0) begin
      fails++; $display("FAIL idle_ready got aw%b ar%b w%b b%b exp 1 1 0 0", s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid);
    end
  endtask
  task automatic test_single();
    logic [511:0] pat = {64{8'hA5}};
    do_aw(64'h40, 8'd0);
    asserts++;
    if (s_axi_wready !== 1 || s_axi_awready !== 0) begin fails++; $display("FAIL single_wready got w%b aw%b exp 1 0", s_axi_wready, s_axi_awready); end
    do_w(pat, '1, 1'b1);
    s_axi_wvalid = 0;
    asserts++;
    if (s_axi_bvalid !== 1) begin fails++; $display("FAIL single_bvalid got %b exp 1", s_axi_bvalid); end
    do_b();
    do_ar(64'h40, 8'd0);
    asserts++;
    if (s_axi_rvalid !== 1 || s_axi_rlast !== 1 || s_axi_rdata !== pat) begin
      fails++; $display("FAIL single_read got v%b l%b %h exp 1 1 %h", s_axi_rvalid, s_axi_rlast, s_axi_rdata, pat);
    end
    s_axi_rready = 1;
    @(negedge aclk);
    s_axi_rready = 0;
    asserts++;
    if (s_axi_rvalid !== 0 || s_axi_rlast !== 0 || s_axi_arready !== 1) begin
      fails++; $display("FAIL single_rdone got v%b l%b ar%b exp 0 0 1", s_axi_rvalid, s_axi_rlast, s_axi_arready);
    end
  endtask
  task automatic test_burst();
    int beat = 0, cyc = 0;
    bit rr = 1, stalled = 0;
    logic [511:0] prev = '0;
    logic prevl = 0;
    do_aw(64'h0, 8'd255);
    for (int i = 0; i < 256; i++) do_w(val(i), '1, i == 255);
    s_axi_wvalid = 0;
    asserts++;
    if (s_axi_bvalid !== 1) begin fails++; $display("FAIL burst_bvalid got %b exp 1", s_axi_bvalid); end
    do_b();
    do_ar(64'h0, 8'd255);
    while (beat < 256 && cyc < 2000) begin
      s_axi_rready = rr;
      if (s_axi_rvalid) begin
        if (stalled) begin
          asserts++;
          if (s_axi_rdata !== prev || s_axi_rlast !== prevl) begin fails++; $display("FAIL burst_stall beat %0d got l%b %h exp l%b %h", beat, s_axi_rlast, s_axi_rdata, prevl, prev); end
        end
        if (rr) begin
          asserts++;
          if (s_axi_rdata !== val(beat) || s_axi_rlast !== (beat == 255)) begin
            fails++; $display("FAIL burst_beat %0d got l%b %h exp l%b %h", beat, s_axi_rlast, s_axi_rdata, beat == 255, val(beat));
          end
          beat++;
        end
        stalled = !rr; prev = s_axi_rdata; prevl = s_axi_rlast;
      end
      @(negedge aclk);
      cyc++;
      rr = !rr;
    end
    s_axi_rready = 0;
    asserts++;
    if (beat != 256 || s_axi_rvalid !== 0) begin fails++; $display("FAIL burst_count got %0d rvalid=%b exp 256 0", beat, s_axi_rvalid); end
  endtask
  task automatic test_strobes();
    logic [511:0] d;
    logic l;
    write1(64'hC0, {64{8'hFF}}, '1);
    write1(64'hC0, '0, {8{8'h0F}});
    read1(64'hC0, d, l);
    asserts++;
    if (d !== {8{64'hFFFF_FFFF_0000_0000}} || l !== 1) begin fails++; $display("FAIL strobe_read got l%b %h exp 1 %h", l, d, {8{64'hFFFF_FFFF_0000_0000}}); end
  endtask
  task automatic test_wrap();
    logic [511:0] d;
    logic l;
    int w [4] = '{1022, 1023, 0, 1};
    do_aw(64'(1022 * 64), 8'd3);
    for (int i = 0; i < 4; i++) do_w(val(1000 + i), '1, i == 3);
    s_axi_wvalid = 0;
    do_b();
    for (int i = 0; i < 4; i++) begin
      read1(64'(w[i] * 64), d, l);
      asserts++;
      if (d !== val(1000 + i)) begin fails++; $display("FAIL wrap_word%0d got %h exp %h", w[i], d, val(1000 + i)); end
    end
  endtask
  task automatic test_wlast_err();
    asserts++;
    if (err_wlast !== 0) begin fails++; $display("FAIL err_pre got %b exp 0", err_wlast); end
    do_aw(64'h100, 8'd3);
    for (int i = 0; i < 4; i++) begin
      do_w(val(2000 + i), '1, i == 1);
      if (i == 2) begin
        asserts++;
        if (s_axi_bvalid !== 0 || err_wlast !== 1) begin fails++; $display("FAIL err_mid got b%b e%b exp 0 1", s_axi_bvalid, err_wlast); end
      end
    end
    s_axi_wvalid = 0;
    asserts++;
    if (s_axi_bvalid !== 1 || err_wlast !== 1) begin fails++; $display("FAIL err_done got b%b e%b exp 1 1", s_axi_bvalid, err_wlast); end
    do_b();
    areset = 1;
    @(negedge aclk);
    areset = 0;
    asserts++;
    if (err_wlast !== 0 || s_axi_awready !== 0) begin fails++; $display("FAIL err_reset got e%b aw%b exp 0 0", err_wlast, s_axi_awready); end
    @(negedge aclk);
  endtask
  task automatic test_back_to_back();
    logic [511:0] oldv = val(3000), newv = val(3001), d;
    logic l;
    write1(64'h140, oldv, '1);
    do_aw(64'h140, 8'd0);
    s_axi_wvalid = 1; s_axi_wdata = newv; s_axi_wstrb = '1; s_axi_wlast = 1;
    s_axi_arvalid = 1; s_axi_araddr = 64'h140; s_axi_arlen = 0;
    @(negedge aclk);
    s_axi_wvalid = 0; s_axi_arvalid = 0;
    asserts++;
    if (s_axi_rvalid !== 1 || s_axi_rdata !== oldv || s_axi_bvalid !== 1) begin
      fails++; $display("FAIL rbw_read got v%b b%b %h exp 1 1 %h", s_axi_rvalid, s_axi_bvalid, s_axi_rdata, oldv);
    end
    s_axi_rready = 1; s_axi_bready = 1;
    @(negedge aclk);
    s_axi_rready = 0; s_axi_bready = 0;
    read1(64'h140, d, l);
    asserts++;
    if (d !== newv) begin fails++; $display("FAIL rbw_after got %h exp %h", d, newv); end
    s_axi_awvalid = 1; s_axi_awaddr = 64'h180; s_axi_awlen = 0;
    s_axi_arvalid = 1; s_axi_araddr = 64'h140; s_axi_arlen = 0;
    @(negedge aclk);
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    asserts++;
    if (s_axi_awready !== 0 || s_axi_arready !== 0 || s_axi_wready !== 1 || s_axi_rvalid !== 1 || s_axi_rdata !== newv) begin
      fails++; $display("FAIL dual_accept got aw%b ar%b w%b r%b %h exp 0 0 1 1 %h", s_axi_awready, s_axi_arready, s_axi_wready, s_axi_rvalid, s_axi_rdata, newv);
    end
    do_w(val(3002), '1, 1'b1);
    s_axi_wvalid = 0;
    s_axi_rready = 1;
    do_b();
    s_axi_rready = 0;
    do_ar(64'h400, 8'd15);
    s_axi_rready = 1;
    @(negedge aclk);
    asserts++;
    if (s_axi_rvalid !== 1 || s_axi_rdata !== val(17)) begin fails++; $display("FAIL midrst_beat2 got v%b %h exp 1 %h", s_axi_rvalid, s_axi_rdata, val(17)); end
    areset = 1;
    @(negedge aclk);
    areset = 0; s_axi_rready = 0;
    asserts++;
    if (s_axi_rvalid !== 0 || s_axi_rlast !== 0 || s_axi_arready !== 0) begin fails++; $display("FAIL midrst_abort got v%b l%b ar%b exp 0 0 0", s_axi_rvalid, s_axi_rlast, s_axi_arready); end
    @(negedge aclk);
    asserts++;
    if (s_axi_arready !== 1 || s_axi_rvalid !== 0) begin fails++; $display("FAIL midrst_release got ar%b v%b exp 1 0", s_axi_arready, s_axi_rvalid); end
    read1(64'h400 + 64'(5 * 64), d, l);
    asserts++;
    if (d !== val(21) || l !== 1) begin fails++; $display("FAIL midrst_reread got l%b %h exp 1 %h", l, d, val(21)); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_strobes();
    test_wrap();
    test_wlast_err();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
